// File: rtl/ontransit_pkg.sv
// Shared types and elaboration-time helpers for the on-transit round-robin arbiter.
package ontransit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT  = 2'd1,
    GAP  = 2'd2
  } state_t;

  function automatic int max_int(input int a, input int b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

  // Bits needed to hold values 0..v-1, never less than one.
  function automatic int clog2_int(input int v);
    int r;
    r = 0;
    while ((32'sd1 <<< r) < v) begin
      r = r + 1;
    end
    if (r < 1) begin
      r = 1;
    end else begin
      r = r;
    end
    return r;
  endfunction

endpackage

// File: rtl/ontransit_arb_rr_pick.sv
// Combinational round-robin picker: first asserted request at or above pointer, wrapping.
module rr_pick #(
  parameter int NCH = 4
) (
  input  logic [NCH-1:0]         req,
  input  logic [$clog2(NCH)-1:0] pointer,
  output logic                   valid,
  output logic [$clog2(NCH)-1:0] index
);

  localparam int IW = $clog2(NCH);

  int pos_s;

  // Scan upward from the pointer and keep the first hit.
  always_comb begin
    valid = 1'b0;
    index = {IW{1'b0}};
    pos_s = 0;
    for (int i = 0; i < NCH; i++) begin
      pos_s = int'(pointer) + i;
      if (pos_s >= NCH) begin
        pos_s = pos_s - NCH;
      end else begin
        pos_s = pos_s;
      end
      if (!valid && req[pos_s[IW-1:0]]) begin
        valid = 1'b1;
        index = pos_s[IW-1:0];
      end else begin
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/ontransit_arb.sv
// Round-robin arbiter with minimum hold, optional timeout and a one-cycle release gap.
// All outputs are registers loaded on state transitions; do_req is the per-channel request.
module ontransit_arb
  import ontransit_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int HOLD_CYC = 3,
  parameter int TIMEOUT  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NCH-1:0]         do_req,
  output logic [NCH-1:0]         g,
  output logic                   s,
  output logic [$clog2(NCH)-1:0] ch,
  output logic                   to_err,
  output logic                   busy
);

  localparam int IW    = $clog2(NCH);
  localparam int CW    = clog2_int(max_int(HOLD_CYC, TIMEOUT) + 1);
  localparam bit TO_EN = (TIMEOUT != 0);

  state_t         state_r, state_n;
  logic [CW-1:0]  cnt_r, cnt_n;
  logic [IW-1:0]  ptr_r, ptr_n;
  logic [NCH-1:0] g_r, g_n;
  logic           s_r, s_n;
  logic [IW-1:0]  ch_r, ch_n;
  logic           to_err_r, to_err_n;
  logic           busy_r, busy_n;
  logic           pick_valid_s;
  logic [IW-1:0]  pick_idx_s;

  rr_pick #(.NCH(NCH)) u_pick (
    .req     (do_req),
    .pointer (ptr_r),
    .valid   (pick_valid_s),
    .index   (pick_idx_s)
  );

  // Next-state and next-output decisions; outputs only change alongside a transition.
  always_comb begin
    state_n  = state_r;
    cnt_n    = cnt_r;
    ptr_n    = ptr_r;
    g_n      = g_r;
    s_n      = 1'b0;
    ch_n     = ch_r;
    to_err_n = 1'b0;
    busy_n   = busy_r;
    case (state_r)
      IDLE: begin
        if (pick_valid_s) begin
          state_n = GNT;
          cnt_n   = {CW{1'b0}};
          g_n     = {{(NCH-1){1'b0}}, 1'b1} << pick_idx_s;
          s_n     = 1'b1;
          ch_n    = pick_idx_s;
          busy_n  = 1'b1;
          if (int'(pick_idx_s) == NCH - 1) begin
            ptr_n = {IW{1'b0}};
          end else begin
            ptr_n = pick_idx_s + IW'(1'b1);
          end
        end else begin
          g_n    = {NCH{1'b0}};
          busy_n = 1'b0;
        end
      end
      GNT: begin
        // cnt_r counts completed grant cycles before this one.
        if (!do_req[ch_r] && (int'(cnt_r) >= HOLD_CYC - 1)) begin
          state_n = GAP;
          g_n     = {NCH{1'b0}};
        end else if (TO_EN && (int'(cnt_r) >= TIMEOUT - 1)) begin
          state_n  = GAP;
          g_n      = {NCH{1'b0}};
          to_err_n = 1'b1;
        end else if (cnt_r != {CW{1'b1}}) begin
          cnt_n = cnt_r + CW'(1'b1);
        end else begin
          cnt_n = cnt_r;
        end
      end
      GAP: begin
        state_n = IDLE;
        g_n     = {NCH{1'b0}};
        busy_n  = 1'b0;
      end
      default: begin
        state_n = IDLE;
        g_n     = {NCH{1'b0}};
        busy_n  = 1'b0;
      end
    endcase
  end

  // State, counter, pointer and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      cnt_r    <= {CW{1'b0}};
      ptr_r    <= {IW{1'b0}};
      g_r      <= {NCH{1'b0}};
      s_r      <= 1'b0;
      ch_r     <= {IW{1'b0}};
      to_err_r <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_n;
      cnt_r    <= cnt_n;
      ptr_r    <= ptr_n;
      g_r      <= g_n;
      s_r      <= s_n;
      ch_r     <= ch_n;
      to_err_r <= to_err_n;
      busy_r   <= busy_n;
    end
  end

  assign g      = g_r;
  assign s      = s_r;
  assign ch     = ch_r;
  assign to_err = to_err_r;
  assign busy   = busy_r;

endmodule

// File: tb/tb_ontransit_arb.sv
// Directed bench for ontransit_arb: default instance plus a TIMEOUT=0 instance on shared stimulus.
module tb_ontransit_arb;

  logic       clk;
  logic       rst;
  logic [3:0] do_req;

  logic [3:0] g, g0;
  logic       s, s0;
  logic [1:0] ch, ch0;
  logic       to_err, to_err0;
  logic       busy, busy0;

  int checks;
  int errors;

  ontransit_arb #(.NCH(4), .HOLD_CYC(3), .TIMEOUT(16)) u_dut (
    .clk (clk), .rst (rst), .do_req (do_req),
    .g (g), .s (s), .ch (ch), .to_err (to_err), .busy (busy)
  );

  ontransit_arb #(.NCH(4), .HOLD_CYC(3), .TIMEOUT(0)) u_dut0 (
    .clk (clk), .rst (rst), .do_req (do_req),
    .g (g0), .s (s0), .ch (ch0), .to_err (to_err0), .busy (busy0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_main(input string tag, input logic [3:0] eg, input logic es,
                          input logic [1:0] ech, input logic eto, input logic eb);
    chk({tag, ".g"}, 32'(g), 32'(eg));
    chk({tag, ".s"}, 32'(s), 32'(es));
    chk({tag, ".ch"}, 32'(ch), 32'(ech));
    chk({tag, ".to_err"}, 32'(to_err), 32'(eto));
    chk({tag, ".busy"}, 32'(busy), 32'(eb));
  endtask

  task automatic chk_zero(input string tag, input logic [3:0] eg, input logic es,
                          input logic [1:0] ech, input logic eto, input logic eb);
    chk({tag, ".g0"}, 32'(g0), 32'(eg));
    chk({tag, ".s0"}, 32'(s0), 32'(es));
    chk({tag, ".ch0"}, 32'(ch0), 32'(ech));
    chk({tag, ".to_err0"}, 32'(to_err0), 32'(eto));
    chk({tag, ".busy0"}, 32'(busy0), 32'(eb));
  endtask

  initial begin
    logic [1:0] order [5];
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    do_req = 4'b0000;

    // Reset held for two cycles with no requests.
    tick(); chk_main("rst1", 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
    tick(); chk_main("rst2", 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;
    tick(); chk_main("idle", 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);

    // Channel 2 held for 10 sampled cycles then dropped.
    do_req = 4'b0100;
    tick(); chk_main("c2_start", 4'b0100, 1'b1, 2'd2, 1'b0, 1'b1);
    for (int i = 1; i < 10; i++) begin
      tick(); chk_main("c2_hold", 4'b0100, 1'b0, 2'd2, 1'b0, 1'b1);
    end
    do_req = 4'b0000;
    tick(); chk_main("c2_gap", 4'b0000, 1'b0, 2'd2, 1'b0, 1'b1);
    tick(); chk_main("c2_idle", 4'b0000, 1'b0, 2'd2, 1'b0, 1'b0);

    // Single-cycle pulse on channel 1 still gets the minimum hold; pointer is 3.
    do_req = 4'b0010;
    tick(); chk_main("c1_start", 4'b0010, 1'b1, 2'd1, 1'b0, 1'b1);
    do_req = 4'b0000;
    tick(); chk_main("c1_hold2", 4'b0010, 1'b0, 2'd1, 1'b0, 1'b1);
    tick(); chk_main("c1_hold3", 4'b0010, 1'b0, 2'd1, 1'b0, 1'b1);
    tick(); chk_main("c1_gap", 4'b0000, 1'b0, 2'd1, 1'b0, 1'b1);
    tick(); chk_main("c1_idle", 4'b0000, 1'b0, 2'd1, 1'b0, 1'b0);

    // Reset to pointer 0, then all channels requesting: rotation 0,1,2,3,0.
    rst = 1'b1;
    tick(); chk_main("rr_rst", 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;
    do_req = 4'b1111;
    order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd2; order[3] = 2'd3; order[4] = 2'd0;
    for (int k = 0; k < 5; k++) begin
      logic [3:0] oh;
      oh = 4'b0001 << order[k];
      tick();
      chk_main("rr_start", oh, 1'b1, order[k], 1'b0, 1'b1);
      chk_zero("rr_start", oh, 1'b1, order[k], 1'b0, 1'b1);
      do_req = 4'b1111 & ~oh;
      tick(); chk_main("rr_hold", oh, 1'b0, order[k], 1'b0, 1'b1);
      tick(); chk_main("rr_hold", oh, 1'b0, order[k], 1'b0, 1'b1);
      tick();
      chk_main("rr_gap", 4'b0000, 1'b0, order[k], 1'b0, 1'b1);
      chk_zero("rr_gap", 4'b0000, 1'b0, order[k], 1'b0, 1'b1);
      do_req = 4'b1111;
      tick(); chk_main("rr_idle", 4'b0000, 1'b0, order[k], 1'b0, 1'b0);
    end
    do_req = 4'b0000;
    tick(); chk_main("rr_quiet", 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);

    // Channel 2 held: timeout after 16 grant cycles on the default instance only.
    do_req = 4'b0100;
    tick();
    chk_main("to_start", 4'b0100, 1'b1, 2'd2, 1'b0, 1'b1);
    chk_zero("to_start", 4'b0100, 1'b1, 2'd2, 1'b0, 1'b1);
    for (int i = 2; i <= 16; i++) begin
      tick(); chk_main("to_hold", 4'b0100, 1'b0, 2'd2, 1'b0, 1'b1);
    end
    tick();
    chk_main("to_release", 4'b0000, 1'b0, 2'd2, 1'b1, 1'b1);
    chk_zero("to_nolimit", 4'b0100, 1'b0, 2'd2, 1'b0, 1'b1);
    tick(); chk_main("to_idle", 4'b0000, 1'b0, 2'd2, 1'b0, 1'b0);
    tick();
    chk_main("to_regrant", 4'b0100, 1'b1, 2'd2, 1'b0, 1'b1);
    chk_zero("to_nolimit2", 4'b0100, 1'b0, 2'd2, 1'b0, 1'b1);

    // Reset, grant channel 3 from pointer 0, then reset in its fifth grant cycle.
    rst = 1'b1;
    do_req = 4'b0000;
    tick(); chk_main("r3_rst", 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;
    do_req = 4'b1000;
    tick(); chk_main("r3_start", 4'b1000, 1'b1, 2'd3, 1'b0, 1'b1);
    for (int i = 2; i <= 5; i++) begin
      tick(); chk_main("r3_hold", 4'b1000, 1'b0, 2'd3, 1'b0, 1'b1);
    end
    rst = 1'b1;
    tick();
    chk_main("r3_midrst", 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
    chk_zero("r3_midrst", 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
    tick(); chk_main("r3_rst_prio", 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    chk_main("r3_regrant", 4'b1000, 1'b1, 2'd3, 1'b0, 1'b1);
    chk_zero("r3_regrant", 4'b1000, 1'b1, 2'd3, 1'b0, 1'b1);
    do_req = 4'b0000;
    tick(); chk_main("r3_hold2", 4'b1000, 1'b0, 2'd3, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
